// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, 5-8 data bits LSB first, optional even parity,
// one or two stop bits; bit period comes from the clock divisor shared with the receiver.
module uart_tx_frame (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        TXen,
   input  logic [12:0] cd,
   input  logic [3:0]  number_data_transmit,
   input  logic        parity_bit_mode,
   input  logic        stop_bit_twice,
   input  logic [7:0]  tx_data,
   input  logic        tx_valid,
   output logic        tx_ready,
   output logic        UART_TXD,
   output logic        busy,
   output logic        done_flag
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_e;

   // Index of the last data bit; unsupported lengths fall back to 5 bits.
   function automatic logic [2:0] last_index(input logic [3:0] n);
      case (n)
         4'd6:    last_index = 3'd5;
         4'd7:    last_index = 3'd6;
         4'd8:    last_index = 3'd7;
         default: last_index = 3'd4;
      endcase
   endfunction

   // Frame control state (reset)
   state_e      state_q, state_d;
   logic        txd_q, txd_d;
   logic        done_q, done_d;
   logic [12:0] baud_q, baud_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic        stop2_q, stop2_d;

   // Per-frame configuration snapshot (captured on accept)
   logic [7:0]  data_q, data_d;
   logic [2:0]  last_idx_q, last_idx_d;
   logic [12:0] period_m1_q, period_m1_d;
   logic        par_en_q, par_en_d;
   logic        two_stop_q, two_stop_d;

   logic        accept;
   logic        bit_end;
   logic [12:0] baud_dec;
   logic [2:0]  next_idx;
   logic [2:0]  new_last;
   logic [12:0] new_period_m1;

   assign tx_ready  = (state_q == ST_IDLE) && TXen && !rst_i;
   assign accept    = tx_valid && tx_ready;
   assign busy      = (state_q != ST_IDLE);
   assign UART_TXD  = txd_q;
   assign done_flag = done_q;

   // The counter holds cycles remaining minus one, so P-1 never exceeds 8190.
   assign bit_end       = (baud_q == 13'd0);
   assign baud_dec      = baud_q - 13'd1;
   assign next_idx      = bit_idx_q + 3'd1;
   assign new_last      = last_index(number_data_transmit);
   assign new_period_m1 = (cd > 13'd1) ? (cd - 13'd1) : 13'd0;

   always_comb begin
      // NOTE: every signal written here gets a default first; a path that leaves one unassigned infers a latch.
      state_d     = state_q;
      txd_d       = txd_q;
      done_d      = 1'b0;
      baud_d      = baud_q;
      bit_idx_d   = bit_idx_q;
      stop2_d     = stop2_q;
      data_d      = data_q;
      last_idx_d  = last_idx_q;
      period_m1_d = period_m1_q;
      par_en_d    = par_en_q;
      two_stop_d  = two_stop_q;

      if (state_q != ST_IDLE) begin
         baud_d = bit_end ? period_m1_q : baud_dec;
      end

      case (state_q)
         ST_IDLE: begin
            txd_d = 1'b1;
            if (accept) begin
               data_d      = tx_data & (8'hFF >> (3'd7 - new_last));
               last_idx_d  = new_last;
               period_m1_d = new_period_m1;
               par_en_d    = parity_bit_mode;
               two_stop_d  = stop_bit_twice;
               baud_d      = new_period_m1;
               txd_d       = 1'b0;
               state_d     = ST_START;
            end
         end

         ST_START: begin
            if (bit_end) begin
               bit_idx_d = 3'd0;
               txd_d     = data_q[0];
               state_d   = ST_DATA;
            end
         end

         ST_DATA: begin
            if (bit_end) begin
               if (bit_idx_q != last_idx_q) begin
                  bit_idx_d = next_idx;
                  txd_d     = data_q[next_idx];
               end else if (par_en_q) begin
                  txd_d   = ^data_q;
                  state_d = ST_PARITY;
               end else begin
                  txd_d   = 1'b1;
                  stop2_d = 1'b0;
                  state_d = ST_STOP;
               end
            end
         end

         ST_PARITY: begin
            if (bit_end) begin
               txd_d   = 1'b1;
               stop2_d = 1'b0;
               state_d = ST_STOP;
            end
         end

         ST_STOP: begin
            txd_d = 1'b1;
            if (bit_end) begin
               if (two_stop_q && !stop2_q) begin
                  stop2_d = 1'b1;
               end else begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end

         default: begin
            txd_d   = 1'b1;
            state_d = ST_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         txd_q     <= 1'b1;
         done_q    <= 1'b0;
         baud_q    <= 13'd0;
         bit_idx_q <= 3'd0;
         stop2_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         txd_q     <= txd_d;
         done_q    <= done_d;
         baud_q    <= baud_d;
         bit_idx_q <= bit_idx_d;
         stop2_q   <= stop2_d;
      end
   end

   // NOTE: the configuration snapshot has no reset; it is always written on accept before anything reads it.
   always_ff @(posedge clk_i) begin
      data_q      <= data_d;
      last_idx_q  <= last_idx_d;
      period_m1_q <= period_m1_d;
      par_en_q    <= par_en_d;
      two_stop_q  <= two_stop_d;
   end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: directed and random frames compared cycle by cycle
// against a bit-list model of the frame format.
module tb_uart_tx_frame;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        TXen;
   logic [12:0] cd;
   logic [3:0]  number_data_transmit;
   logic        parity_bit_mode;
   logic        stop_bit_twice;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        UART_TXD;
   logic        busy;
   logic        done_flag;

   int n_checks = 0;
   int n_fail   = 0;
   bit exp_bits[$];

   uart_tx_frame dut (
      .clk_i                (clk_i),
      .rst_i                (rst_i),
      .TXen                 (TXen),
      .cd                   (cd),
      .number_data_transmit (number_data_transmit),
      .parity_bit_mode      (parity_bit_mode),
      .stop_bit_twice       (stop_bit_twice),
      .tx_data              (tx_data),
      .tx_valid             (tx_valid),
      .tx_ready             (tx_ready),
      .UART_TXD             (UART_TXD),
      .busy                 (busy),
      .done_flag            (done_flag)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Frame as a list of line levels, one entry per bit period.
   function automatic void build_frame(input logic [7:0] word, input logic [3:0] ndt,
                                       input logic par, input logic two);
      int n;
      bit p;
      n = (ndt >= 4'd5 && ndt <= 4'd8) ? int'(ndt) : 5;
      p = 1'b0;
      exp_bits.delete();
      exp_bits.push_back(1'b0);
      for (int i = 0; i < n; i++) begin
         exp_bits.push_back(word[i]);
         p = p ^ word[i];
      end
      if (par) exp_bits.push_back(p);
      exp_bits.push_back(1'b1);
      if (two) exp_bits.push_back(1'b1);
   endfunction

   function automatic int bit_period(input logic [12:0] c);
      return (c < 13'd2) ? 1 : int'(c);
   endfunction

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk_i);
         check("idle_done", done_flag, 1'b0);
         check("idle_busy", busy, 1'b0);
         check("idle_txd", UART_TXD, 1'b1);
      end
   endtask

   // Called at a negedge: present a word, then check every frame cycle and the done cycle.
   task automatic run_frame(input logic [7:0] word, input logic [3:0] ndt, input logic par,
                            input logic two, input logic [12:0] cdv, input bit hold,
                            input logic [7:0] next_word, input bit disturb, input int abort_at);
      int p;
      int len;
      build_frame(word, ndt, par, two);
      p   = bit_period(cdv);
      len = exp_bits.size() * p;
      tx_data              = word;
      number_data_transmit = ndt;
      parity_bit_mode      = par;
      stop_bit_twice       = two;
      cd                   = cdv;
      tx_valid             = 1'b1;
      #1 check("accept_ready", tx_ready, 1'b1);
      @(posedge clk_i);
      @(negedge clk_i);
      if (hold) tx_data = next_word;
      else      tx_valid = 1'b0;
      for (int c = 0; c < len; c++) begin
         if (c > 0) @(negedge clk_i);
         check($sformatf("txd w=%0h c=%0d", word, c), UART_TXD, exp_bits[c / p]);
         check($sformatf("busy c=%0d", c), busy, 1'b1);
         check($sformatf("done_low c=%0d", c), done_flag, 1'b0);
         check($sformatf("ready_low c=%0d", c), tx_ready, 1'b0);
         if (disturb && c == 2 * p + 1) begin
            cd                   = 13'd9;
            number_data_transmit = 4'd5;
            TXen                 = 1'b0;
         end
         if (c == abort_at) begin
            rst_i = 1'b1;
            return;
         end
      end
      @(negedge clk_i);
      check($sformatf("done_pulse w=%0h", word), done_flag, 1'b1);
      check("done_busy", busy, 1'b0);
      check("done_txd", UART_TXD, 1'b1);
      check("done_ready", tx_ready, TXen);
   endtask

   initial begin
      int low;
      logic [7:0] w;

      rst_i                = 1'b1;
      TXen                 = 1'b1;
      cd                   = 13'd4;
      number_data_transmit = 4'd8;
      parity_bit_mode      = 1'b0;
      stop_bit_twice       = 1'b0;
      tx_data              = 8'h00;
      tx_valid             = 1'b0;
      repeat (3) @(negedge clk_i);
      check("rst_txd", UART_TXD, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done_flag, 1'b0);
      check("rst_ready", tx_ready, 1'b0);
      rst_i = 1'b0;
      #1 check("post_rst_ready", tx_ready, 1'b1);
      idle(2);

      // 8N1, cd=4, 0xA5
      run_frame(8'hA5, 4'd8, 1'b0, 1'b0, 13'd4, 1'b0, 8'h00, 1'b0, -1);
      idle(2);

      // 7 bits, parity, two stops, cd=3, 0x87
      run_frame(8'h87, 4'd7, 1'b1, 1'b1, 13'd3, 1'b0, 8'h00, 1'b0, -1);
      idle(1);

      // Back-to-back with tx_valid held
      run_frame(8'h55, 4'd8, 1'b0, 1'b0, 13'd2, 1'b1, 8'h0F, 1'b0, -1);
      run_frame(8'h0F, 4'd8, 1'b0, 1'b0, 13'd2, 1'b0, 8'h00, 1'b0, -1);
      idle(2);

      // Mid-frame configuration change and TXen drop
      w = 8'($urandom);
      run_frame(w, 4'd8, 1'b0, 1'b0, 13'd5, 1'b0, 8'h00, 1'b1, -1);
      tx_data  = 8'h3C;
      tx_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         check("txen_off_ready", tx_ready, 1'b0);
         check("txen_off_busy", busy, 1'b0);
      end
      TXen = 1'b1;
      run_frame(8'h3C, 4'd8, 1'b0, 1'b0, 13'd5, 1'b0, 8'h00, 1'b0, -1);
      idle(1);

      // Reset during data bit 3 (cd=4: frame cycles 16..19)
      w = 8'($urandom);
      run_frame(w, 4'd8, 1'b0, 1'b0, 13'd4, 1'b0, 8'h00, 1'b0, 17);
      @(negedge clk_i);
      check("abort_txd", UART_TXD, 1'b1);
      check("abort_busy", busy, 1'b0);
      check("abort_done", done_flag, 1'b0);
      check("abort_ready", tx_ready, 1'b0);
      rst_i = 1'b0;
      idle(3);
      run_frame(8'hC3, 4'd8, 1'b0, 1'b0, 13'd4, 1'b0, 8'h00, 1'b0, -1);

      // Divisor and length boundaries
      run_frame(8'($urandom), 4'd8, 1'b1, 1'b0, 13'd0, 1'b0, 8'h00, 1'b0, -1);
      run_frame(8'($urandom), 4'd6, 1'b0, 1'b1, 13'd1, 1'b0, 8'h00, 1'b0, -1);
      idle(1);
      run_frame(8'hFF, 4'd12, 1'b1, 1'b0, 13'd2, 1'b0, 8'h00, 1'b0, -1);
      run_frame(8'($urandom), 4'd0, 1'b0, 1'b0, 13'd3, 1'b0, 8'h00, 1'b0, -1);

      // Random formats
      for (int i = 0; i < 12; i++) begin
         idle($urandom_range(0, 2));
         run_frame(8'($urandom), 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
                   13'($urandom_range(0, 6)), 1'b0, 8'h00, 1'b0, -1);
      end
      idle(2);

      // Largest divisor: start bit spans exactly 8191 cycles
      tx_data              = 8'h01;
      number_data_transmit = 4'd5;
      parity_bit_mode      = 1'b0;
      stop_bit_twice       = 1'b0;
      cd                   = 13'd8191;
      tx_valid             = 1'b1;
      #1 check("max_cd_ready", tx_ready, 1'b1);
      @(posedge clk_i);
      @(negedge clk_i);
      tx_valid = 1'b0;
      low = 0;
      for (int c = 0; c < 8191; c++) begin
         if (c > 0) @(negedge clk_i);
         if (UART_TXD === 1'b0) low++;
      end
      check("max_cd_start_len", low, 8191);
      @(negedge clk_i);
      check("max_cd_bit0", UART_TXD, 1'b1);
      check("max_cd_busy", busy, 1'b1);
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);
      check("max_cd_rst_txd", UART_TXD, 1'b1);
      check("max_cd_rst_busy", busy, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
